// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and types for the register-file write scheduler.
// The sizes here must track the register file's own package.
package PkgRegFileWriteSched;

    localparam int NUM_REQ    = 3;
    localparam int NUM_REGS   = 16;
    localparam int DATA_WIDTH = 32;
    localparam int SEL_W      = $clog2(NUM_REGS);

    typedef logic [SEL_W-1:0]      reg_sel_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        logic     valid;
        reg_sel_t sel;
        data_t    data;
    } wb_req_t;

    typedef logic [1:0] sb_count_t;
    localparam sb_count_t SB_COUNT_MAX = 2'd3;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr upward and moves the pointer
// just past the winner, so every valid requester is served within N grants.
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    int               idx;
    logic             found;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        found         = 1'b0;
        idx           = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(rr_ptr_q) + off) % N;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = IDX_W'(idx);
                rr_ptr_d      = IDX_W'((idx + 1) % N);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates writeback sources onto the single register-file write port and
// keeps a per-register outstanding-write scoreboard for hazard stalls.
module regfile_write_scheduler
    import PkgRegFileWriteSched::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic     [NUM_REQ-1:0]  req_valid,
    input  reg_sel_t [NUM_REQ-1:0]  req_sel,
    input  data_t    [NUM_REQ-1:0]  req_data,
    output logic     [NUM_REQ-1:0]  req_ready,
    input  logic                    rsv_en,
    input  reg_sel_t                rsv_sel,
    output logic                    rf_write_en,
    output reg_sel_t                rf_write_sel,
    output data_t                   rf_write_data,
    output logic     [NUM_REGS-1:0] pending,
    output logic                    sb_error
);

    localparam int IDX_W = $clog2(NUM_REQ);

    wb_req_t [NUM_REQ-1:0] reqs;
    wb_req_t               granted;
    logic    [IDX_W-1:0]   grant_idx;
    logic                  grant_valid;
    logic                  accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i] = '{valid: req_valid[i], sel: req_sel[i], data: req_data[i]};
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_valid),
        .grant_o       (req_ready),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign granted = reqs[grant_idx];
    assign accept  = grant_valid && granted.valid;

    // Output slot: drains every cycle; writes aimed at r0 are accepted but never enabled.
    logic     en_q, en_d;
    reg_sel_t sel_q, sel_d;
    data_t    data_q, data_d;

    always_comb begin
        en_d   = 1'b0;
        sel_d  = sel_q;
        data_d = data_q;
        if (accept) begin
            en_d   = (granted.sel != '0);
            sel_d  = granted.sel;
            data_d = granted.data;
        end
    end

    // Scoreboard: a simultaneous reserve and commit on one register cancel out.
    sb_count_t [NUM_REGS-1:0] count_q, count_d;
    logic                     err_q, err_d;
    logic                     inc, dec;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc = rsv_en && (rsv_sel == reg_sel_t'(r));
            dec = en_q && (sel_q == reg_sel_t'(r));
            if (inc && !dec) begin
                if (count_q[r] == SB_COUNT_MAX) err_d = 1'b1;
                else                            count_d[r] = count_q[r] + 2'd1;
            end else if (dec && !inc) begin
                if (count_q[r] == '0) err_d = 1'b1;
                else                  count_d[r] = count_q[r] - 2'd1;
            end
        end
        count_d[0] = '0;
    end

    // NOTE: the count array is reset because pending must read all-zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (count_q[r] != '0);
        end
    end

    assign rf_write_en   = en_q;
    assign rf_write_sel  = sel_q;
    assign rf_write_data = data_q;
    assign sb_error      = err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed vector table, hand-written
// scoreboard/reset sequences, then random traffic against a reference model.
module tb_regfile_write_scheduler;

    localparam int NR = 3;
    localparam int NG = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NR-1:0]         req_valid = '0;
    logic [NR-1:0][3:0]    req_sel = '0;
    logic [NR-1:0][31:0]   req_data = '0;
    logic [NR-1:0]         req_ready;
    logic                  rsv_en = 1'b0;
    logic [3:0]            rsv_sel = '0;
    logic                  rf_write_en;
    logic [3:0]            rf_write_sel;
    logic [31:0]           rf_write_data;
    logic [NG-1:0]         pending;
    logic                  sb_error;

    regfile_write_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_sel       (req_sel),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsv_en        (rsv_en),
        .rsv_sel       (rsv_sel),
        .rf_write_en   (rf_write_en),
        .rf_write_sel  (rf_write_sel),
        .rf_write_data (rf_write_data),
        .pending       (pending),
        .sb_error      (sb_error)
    );

    always #5 clk = ~clk;

    // Register file driven by the scheduler's write port.
    logic [31:0] rf_mem [NG];
    initial for (int r = 0; r < NG; r++) rf_mem[r] = '0;
    always @(posedge clk) if (rf_write_en) rf_mem[rf_write_sel] <= rf_write_data;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int          m_ptr;
    int          m_cnt [NG];
    logic        m_err;
    logic        m_en;
    logic [3:0]  m_sel;
    logic [31:0] m_data;

    task automatic model_reset();
        m_ptr = 0;
        m_err = 1'b0;
        m_en = 1'b0;
        m_sel = '0;
        m_data = '0;
        for (int r = 0; r < NG; r++) m_cnt[r] = 0;
    endtask

    function automatic int model_grant(input logic [NR-1:0] v);
        for (int o = 0; o < NR; o++) if (v[(m_ptr + o) % NR]) return (m_ptr + o) % NR;
        return -1;
    endfunction

    function automatic logic [NG-1:0] model_pending();
        logic [NG-1:0] p = '0;
        for (int r = 0; r < NG; r++) p[r] = (m_cnt[r] != 0);
        return p;
    endfunction

    // One clock cycle: called just after a rising edge, returns just after the next one.
    task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0][3:0] s,
                         input logic [NR-1:0][31:0] d, input logic re, input logic [3:0] rs,
                         output logic [NR-1:0] got_ready, output int k);
        logic [NR-1:0] exp_ready;
        req_valid = v; req_sel = s; req_data = d; rsv_en = re; rsv_sel = rs;
        #1;
        k = model_grant(v);
        exp_ready = (k < 0) ? '0 : (NR'(1) << k);
        got_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        @(posedge clk);
        for (int r = 1; r < NG; r++) begin
            bit inc = re && (rs == r);
            bit dec = m_en && (m_sel == r);
            if (inc && !dec) begin
                if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r]++;
            end else if (dec && !inc) begin
                if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
            end
        end
        if (k >= 0) begin
            m_en = (s[k] != 0); m_sel = s[k]; m_data = d[k];
            m_ptr = (k + 1) % NR;
        end else begin
            m_en = 1'b0;
        end
        #1;
        check("rf_write_en", rf_write_en, m_en);
        check("rf_write_sel", rf_write_sel, m_sel);
        check("rf_write_data", rf_write_data, m_data);
        check("pending", pending, model_pending());
        check("sb_error", sb_error, m_err);
    endtask

    task automatic idle();
        logic [NR-1:0] rd; int k;
        cycle('0, '0, '0, 1'b0, 4'd0, rd, k);
    endtask

    task automatic reserve(input logic [3:0] r);
        logic [NR-1:0] rd; int k;
        cycle('0, '0, '0, 1'b1, r, rd, k);
    endtask

    task automatic write0(input logic [3:0] r, input logic [31:0] d, input logic re, input logic [3:0] rs);
        logic [NR-1:0] rd; int k;
        cycle(3'b001, {4'd0, 4'd0, r}, {32'd0, 32'd0, d}, re, rs, rd, k);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; rsv_en = 1'b0;
        #1;
        check("rst_en", rf_write_en, 1'b0);
        check("rst_sel", rf_write_sel, 4'd0);
        check("rst_data", rf_write_data, 32'd0);
        check("rst_pending", pending, '0);
        check("rst_sb_error", sb_error, 1'b0);
        check("rst_ready_none", req_ready, 3'b000);
        req_valid = 3'b110;
        #1;
        check("rst_ready_rule", req_ready, 3'b010);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NR-1:0]       v;
        logic [NR-1:0][3:0]  s;
        logic [NR-1:0][31:0] d;
        logic [NR-1:0]       exp_ready;
        logic                exp_en;
        logic [3:0]          exp_sel;
        logic [31:0]         exp_data;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [NR-1:0]       rd;
        int                  k;
        logic [NR-1:0]       cur_v;
        logic [NR-1:0][3:0]  cur_s;
        logic [NR-1:0][31:0] cur_d;

        tbl[0] = '{3'b001, {4'd3, 4'd2, 4'd5}, {32'hA3, 32'hA2, 32'hDEADBEEF}, 3'b001, 1'b1, 4'd5, 32'hDEADBEEF};
        tbl[1] = '{3'b000, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1}, 3'b000, 1'b0, 4'd5, 32'hDEADBEEF};
        tbl[2] = '{3'b111, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1}, 3'b010, 1'b1, 4'd2, 32'hA2};
        tbl[3] = '{3'b111, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1}, 3'b100, 1'b1, 4'd3, 32'hA3};
        tbl[4] = '{3'b111, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1}, 3'b001, 1'b1, 4'd1, 32'hA1};
        tbl[5] = '{3'b101, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1}, 3'b100, 1'b1, 4'd3, 32'hA3};
        tbl[6] = '{3'b110, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1}, 3'b010, 1'b1, 4'd2, 32'hA2};
        tbl[7] = '{3'b001, {4'd3, 4'd2, 4'd0}, {32'hA3, 32'hA2, 32'h1234}, 3'b001, 1'b0, 4'd0, 32'h1234};

        model_reset();
        do_reset();

        // Directed vectors from reset: grant order, hold on idle, r0 drop.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].d, 1'b0, 4'd0, rd, k);
            check($sformatf("tbl%0d_ready", i), rd, tbl[i].exp_ready);
            check($sformatf("tbl%0d_en", i), rf_write_en, tbl[i].exp_en);
            check($sformatf("tbl%0d_sel", i), rf_write_sel, tbl[i].exp_sel);
            check($sformatf("tbl%0d_data", i), rf_write_data, tbl[i].exp_data);
            if (i == 1) check("rf_r5_readback", rf_mem[5], 32'hDEADBEEF);
        end
        idle();
        check("rf_r0_untouched", rf_mem[0], 32'd0);

        // Two reservations of r3 retired by two commits.
        do_reset();
        reserve(4'd3);
        reserve(4'd3);
        write0(4'd3, 32'h11, 1'b0, 4'd0);
        write0(4'd3, 32'h22, 1'b0, 4'd0);
        check("r3_pending_after_1st_commit", pending[3], 1'b1);
        idle();
        check("r3_pending_after_2nd_commit", pending[3], 1'b0);
        check("r3_no_error", sb_error, 1'b0);

        // Reserve colliding with a commit on r7, then overflow at count 3.
        reserve(4'd7);
        write0(4'd7, 32'h77, 1'b0, 4'd0);
        reserve(4'd7);
        check("r7_collide_pending", pending[7], 1'b1);
        check("r7_collide_no_error", sb_error, 1'b0);
        reserve(4'd7);
        reserve(4'd7);
        reserve(4'd7);
        check("r7_overflow_error", sb_error, 1'b1);
        write0(4'd7, 32'h71, 1'b0, 4'd0);
        write0(4'd7, 32'h72, 1'b0, 4'd0);
        write0(4'd7, 32'h73, 1'b0, 4'd0);
        check("r7_pending_before_last_commit", pending[7], 1'b1);
        idle();
        check("r7_drained", pending[7], 1'b0);
        check("r7_error_sticky", sb_error, 1'b1);

        // Reset while the slot holds r2 = 0xAA.
        do_reset();
        reserve(4'd2);
        cycle(3'b010, {4'd0, 4'd2, 4'd0}, {32'd0, 32'hAA, 32'd0}, 1'b0, 4'd0, rd, k);
        check("slot_r2_loaded", rf_write_en, 1'b1);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en_drop", rf_write_en, 1'b0);
        check("mid_rst_pending", pending, '0);
        @(posedge clk);
        #1;
        check("mid_rst_r2_unchanged", rf_mem[2], 32'hA2);
        rst_n = 1'b1;
        model_reset();
        cycle(3'b111, {4'd3, 4'd2, 4'd1}, {32'hC3, 32'hC2, 32'hC1}, 1'b0, 4'd0, rd, k);
        check("post_rst_grant0", rd, 3'b001);

        // Random traffic; requesters hold their request until granted.
        do_reset();
        cur_v = '0; cur_s = '0; cur_d = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!cur_v[i]) begin
                    cur_v[i] = ($urandom_range(0, 1) == 1);
                    cur_s[i] = 4'($urandom_range(0, NG - 1));
                    cur_d[i] = $urandom;
                end
            end
            cycle(cur_v, cur_s, cur_d, ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, NG - 1)), rd, k);
            if (k >= 0) cur_v[k] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the register file's single synchronous write port among several writeback sources (single-cycle ALU, multi-cycle mul/div, load unit) with round-robin arbitration and a valid/ready handshake per source. Tracks outstanding writes per register in a scoreboard so the issue stage can stall on RAW/WAW hazards. Sits between the execute/writeback units and the register file. Drives the register file's write_en/write_sel/write_data inputs.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- NUM_REGS, 16, register count; must match the register file
- DATA_WIDTH, 32, register data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_sel  in  NUM_REQ x log2(NUM_REGS)  destination register per requester
- req_data  in  NUM_REQ x DATA_WIDTH  write data per requester
- req_ready  out  NUM_REQ  one-hot grant; the transfer occurs when valid&ready at the clock edge
- rsv_en  in  1  issue stage reserves a destination register
- rsv_sel  in  log2(NUM_REGS)  register being reserved
- rf_write_en  out  1  to register file write_en
- rf_write_sel  out  log2(NUM_REGS)  to register file write_sel
- rf_write_data  out  DATA_WIDTH  to register file write_data
- pending  out  NUM_REGS  bit r set while register r has an outstanding reserved write
- sb_error  out  1  sticky; scoreboard overflow or underflow detected

## Operation
- Arbitration: round-robin pointer rr_ptr. Grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
- On grant k: rr_ptr <= (k+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
- At most one grant per cycle. req_ready is combinational from req_valid and rr_ptr. req_ready is 0 for every requester when none is valid.
- Requesters hold req_valid/req_sel/req_data stable until accepted. req_ready never depends on its own requester's data.
- Output stage: a registered write slot that always drains, because the register file accepts every cycle.
  - On acceptance the slot loads rf_write_sel/rf_write_data with the granted values.
  - rf_write_en is set to 1 when the granted sel != 0, and to 0 otherwise. Writes to r0 are accepted and dropped.
  - With no acceptance, rf_write_en is 0 next cycle. sel/data hold their previous values.
- Scoreboard: a 2-bit count per register; pending[r] = (count[r] != 0). count[0] is always 0.
  - Increment: rsv_en with rsv_sel != 0.
  - Decrement: rf_write_en asserted with rf_write_sel == r, i.e. the commit cycle.
  - Increment and decrement of the same register in the same cycle: count unchanged.
  - Increment at count 3: ignored, sb_error <= 1.
  - Decrement at count 0: count stays 0, sb_error <= 1.
  - rsv_en with rsv_sel == 0: no effect.
- sb_error is cleared only by reset.

## Timing
- Accept at edge t → rf_write_* valid during cycle t+1 → register file updated and scoreboard decremented at edge t+1.
- Reserve at edge t → pending visible in cycle t+1.
- Throughput: one write per cycle sustained.
- Fairness: no valid requester waits more than NUM_REQ−1 grants.
- Reset values:
  - rf_write_en 0, rf_write_sel 0, rf_write_data 0.
  - All counts 0, so pending all 0.
  - rr_ptr 0, sb_error 0.
  - req_ready follows its combinational rule from reset state.
- Reset asserted mid-operation discards the in-flight slot. The register file is not written that cycle.

## Structure
- Shared package PkgRegFileWriteSched holds:
  - the NUM_REQ, NUM_REGS and DATA_WIDTH constants, kept consistent with the register file package;
  - the typedefs for the register select, the data word and the per-requester request struct (valid, sel, data);
  - the typedef for the 2-bit scoreboard count.
- One sub-module, rr_arbiter: a parameterised round-robin arbiter holding rr_ptr, with req vector in and one-hot grant plus grant index out.
- The scoreboard and the output slot live in the top module.

## Test plan
- Single source: req0 writes r5=0xDEADBEEF at edge t → rf_write_en=1, sel=5, data=0xDEADBEEF in cycle t+1; register file reads back 0xDEADBEEF in t+2.
- All three valid continuously from reset → grants 0,1,2,0,1,2 on consecutive cycles; each requester's data appears on rf_write_data one cycle after its grant.
- Write to r0 with data 0x1234 → req_ready asserted, rf_write_en stays 0, register file r0 still reads 0.
- Reserve r3 twice, then commit two writes to r3 → pending[3] stays 1 until the edge after the second commit; sb_error stays 0.
- Reserve r7 in the same cycle that a commit to r7 occurs with count 1 → count remains 1; a fourth reserve at count 3 sets sb_error=1 and the count stays 3.
- Assert rst_n=0 while the slot holds r2=0xAA → rf_write_en drops to 0 immediately, r2 unchanged, pending all 0, next grant goes to requester 0.
